priority_queue_kv: RTL

//  Sorted key+payload priority queue with valid/ready push and pop ports.

---
 rtl/priority_queue_kv_pkg.sv | 25 ++
 rtl/priority_queue_kv_cell.sv | 72 +++++++
 rtl/priority_queue_kv.sv | 127 ++++++++++++
 3 files changed

// File: rtl/priority_queue_kv_pkg.sv
// Shared types and helpers for the sorted key+payload priority queue.
// Keys wider than PQ_KEY_MAX_W bits are not supported by pq_before.
package priority_queue_kv_pkg;

    localparam int PQ_KEY_MAX_W = 32;

    typedef enum logic [1:0] {
        PQ_IDLE,
        PQ_PUSH,
        PQ_POP,
        PQ_REPLACE
    } pq_op_e;

    function automatic int pq_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Strict ordering, so an equal key never overtakes an existing entry.
    function automatic logic pq_before(input logic [PQ_KEY_MAX_W-1:0] a,
                                       input logic [PQ_KEY_MAX_W-1:0] b,
                                       input logic                    max_first);
        return max_first ? (a > b) : (a < b);
    endfunction

endpackage

// File: rtl/priority_queue_kv_cell.sv
// One storage slot of the priority queue: holds, shifts from a neighbour,
// or captures the incoming entry depending on the decoded operation.
module priority_queue_kv_cell
    import priority_queue_kv_pkg::*;
#(
    parameter int KEY_W     = 10,
    parameter int PAYLOAD_W = 8
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  pq_op_e               i_op,
    input  logic                 i_ins_here,
    input  logic                 i_ins_left,
    input  logic [KEY_W-1:0]     i_left_key,
    input  logic [PAYLOAD_W-1:0] i_left_data,
    input  logic [KEY_W-1:0]     i_right_key,
    input  logic [PAYLOAD_W-1:0] i_right_data,
    input  logic [KEY_W-1:0]     i_new_key,
    input  logic [PAYLOAD_W-1:0] i_new_data,
    output logic [KEY_W-1:0]     o_key,
    output logic [PAYLOAD_W-1:0] o_data
);

    logic [KEY_W-1:0]     key_q, key_d;
    logic [PAYLOAD_W-1:0] data_q, data_d;

    // On replace, slots past the insert point already sit at their post-pop
    // position, so they hold rather than shift.
    always_comb begin
        key_d  = key_q;
        data_d = data_q;
        case (i_op)
            PQ_PUSH: begin
                if (i_ins_here) begin
                    key_d  = i_new_key;
                    data_d = i_new_data;
                end else if (i_ins_left) begin
                    key_d  = i_left_key;
                    data_d = i_left_data;
                end
            end
            PQ_POP: begin
                key_d  = i_right_key;
                data_d = i_right_data;
            end
            PQ_REPLACE: begin
                if (i_ins_here) begin
                    key_d  = i_new_key;
                    data_d = i_new_data;
                end else if (!i_ins_left) begin
                    key_d  = i_right_key;
                    data_d = i_right_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            key_q  <= '0;
            data_q <= '0;
        end else begin
            key_q  <= key_d;
            data_q <= data_d;
        end
    end

    assign o_key  = key_q;
    assign o_data = data_q;

endmodule

// File: rtl/priority_queue_kv.sv
// Sorted key+payload priority queue, head always registered in slot 0.
// Optional PRIORITY_QUEUE_KV_FLUSH_EN adds i_flush to drop all entries.
module priority_queue_kv
    import priority_queue_kv_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int KEY_W     = 10,
    parameter int PAYLOAD_W = 8,
    parameter int MAX_FIRST = 0
) (
    input  logic                         CLK,
    input  logic                         RSTn,
`ifdef PRIORITY_QUEUE_KV_FLUSH_EN
    input  logic                         i_flush,
`endif
    input  logic                         i_push_valid,
    output logic                         o_push_ready,
    input  logic [KEY_W-1:0]             i_push_key,
    input  logic [PAYLOAD_W-1:0]         i_push_data,
    output logic                         o_pop_valid,
    input  logic                         i_pop_ready,
    output logic [KEY_W-1:0]             o_pop_key,
    output logic [PAYLOAD_W-1:0]         o_pop_data,
    output logic [pq_cnt_w(DEPTH)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int CNT_W = pq_cnt_w(DEPTH);

    logic [KEY_W-1:0]     slot_key  [DEPTH];
    logic [PAYLOAD_W-1:0] slot_data [DEPTH];

    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             flush;
    logic             push_fire, pop_fire;
    pq_op_e           op;
    logic [DEPTH-1:0] after_new, ins_ge, ins_here, ins_left;

`ifdef PRIORITY_QUEUE_KV_FLUSH_EN
    assign flush = i_flush;
`else
    assign flush = 1'b0;
`endif

    assign o_push_ready = !flush && (!full_q || i_pop_ready);
    assign o_pop_valid  = !empty_q;
    assign push_fire    = i_push_valid && o_push_ready;
    assign pop_fire     = o_pop_valid && i_pop_ready && !flush;

    always_comb begin
        op = PQ_IDLE;
        if (push_fire && pop_fire) op = PQ_REPLACE;
        else if (push_fire)        op = PQ_PUSH;
        else if (pop_fire)         op = PQ_POP;
    end

    // after_new[i]: the new entry belongs at or before slot i (empty slots count as yes).
    // The sorted contents make this vector a single 0->1 step, so the insert point is its edge.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            after_new[i] = (i >= int'(count_q)) ||
                           pq_before(PQ_KEY_MAX_W'(i_push_key), PQ_KEY_MAX_W'(slot_key[i]),
                                     MAX_FIRST != 0);
        end
        ins_ge   = (op == PQ_REPLACE) ? {1'b1, after_new[DEPTH-1:1]} : after_new;
        ins_left = {ins_ge[DEPTH-2:0], 1'b0};
        ins_here = ins_ge & ~ins_left;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        localparam int L = (g == 0) ? 0 : g - 1;
        localparam int R = (g == DEPTH - 1) ? g : g + 1;

        priority_queue_kv_cell #(
            .KEY_W    (KEY_W),
            .PAYLOAD_W(PAYLOAD_W)
        ) u_cell (
            .CLK         (CLK),
            .RSTn        (RSTn),
            .i_op        (op),
            .i_ins_here  (ins_here[g]),
            .i_ins_left  (ins_left[g]),
            .i_left_key  (slot_key[L]),
            .i_left_data (slot_data[L]),
            .i_right_key (slot_key[R]),
            .i_right_data(slot_data[R]),
            .i_new_key   (i_push_key),
            .i_new_data  (i_push_data),
            .o_key       (slot_key[g]),
            .o_data      (slot_data[g])
        );
    end

    always_comb begin
        count_d = count_q;
        case (op)
            PQ_PUSH: count_d = count_q + CNT_W'(1);
            PQ_POP:  count_d = count_q - CNT_W'(1);
            default: ;
        endcase
        if (flush) count_d = '0;
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign o_count    = count_q;
    assign o_full     = full_q;
    assign o_empty    = empty_q;
    assign o_pop_key  = slot_key[0];
    assign o_pop_data = slot_data[0];

endmodule
